// File: rtl/clock_pkg.sv
// Shared constants and BCD helper for the digital clock timekeeping core.
package clock_pkg;

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_SET_HR  = 2'b01;
  localparam logic [1:0] ST_SET_MIN = 2'b10;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam logic [7:0] HR_MAX      = 8'h23;
  localparam logic [7:0] MS_MAX      = 8'h59;

  // Increment a packed two-digit BCD value, wrapping to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (val == max) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/clock_time_core_if.sv
// Button inputs and display/status outputs of the clock timekeeping core.
interface clock_time_core_if;

  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] data1;
  logic [3:0] data2;
  logic [3:0] data3;
  logic [3:0] data4;
  logic       sec_tick;
  logic [1:0] mode;

  modport master (
    output btn_mode, btn_inc,
    input  data1, data2, data3, data4, sec_tick, mode
  );

  modport slave (
    input  btn_mode, btn_inc,
    output data1, data2, data3, data4, sec_tick, mode
  );

endinterface

// File: rtl/clock_time_core_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stable-level filter, one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input differs from the accepted level.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser and filter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_time_core.sv
// 24-hour BCD timekeeping core with 1 Hz prescaler, hour/minute set mode and blinking edit field.
module clock_time_core
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned BLINK_DIV    = 12_500_000
) (
  input logic              clk,
  input logic              rst_n,
  clock_time_core_if.slave bus
);

  localparam int unsigned PW = $clog2(CLK_HZ + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic          mode_press_s, inc_press_s;
  logic [1:0]    state_q, state_d;
  logic [7:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d, bcnt_step_s;
  logic          blink_q, blink_d, blink_step_s;
  logic          sec_tick_q, sec_tick_d;
  logic [1:0]    mode_q, mode_d;
  logic [3:0]    data1_q, data1_d, data2_q, data2_d, data3_q, data3_d, data4_q, data4_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.btn_mode),
    .press_o (mode_press_s)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.btn_inc),
    .press_o (inc_press_s)
  );

  // Free-running blink step used while an edit field is shown.
  always_comb begin
    if (bcnt_q == BLINK_LAST) begin
      bcnt_step_s  = '0;
      blink_step_s = ~blink_q;
    end else begin
      bcnt_step_s  = bcnt_q + BW'(1);
      blink_step_s = blink_q;
    end
  end

  // Mode FSM, prescaler, BCD time counters; a mode press always pre-empts inc.
  always_comb begin
    state_d    = state_q;
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    presc_d    = presc_q;
    bcnt_d     = '0;
    blink_d    = 1'b0;
    sec_tick_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_press_s) begin
          state_d = ST_SET_HR;
          presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d    = '0;
          sec_tick_d = 1'b1;
          sec_d      = bcd_inc(sec_q, MS_MAX);
          if (sec_q == MS_MAX) begin
            min_d = bcd_inc(min_q, MS_MAX);
            if (min_q == MS_MAX) begin
              hr_d = bcd_inc(hr_q, HR_MAX);
            end else begin
              hr_d = hr_q;
            end
          end else begin
            min_d = min_q;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_SET_HR: begin
        presc_d = '0;
        if (mode_press_s) begin
          state_d = ST_SET_MIN;
        end else if (inc_press_s) begin
          hr_d = bcd_inc(hr_q, HR_MAX);
        end else begin
          bcnt_d  = bcnt_step_s;
          blink_d = blink_step_s;
        end
      end
      ST_SET_MIN: begin
        presc_d = '0;
        if (mode_press_s) begin
          state_d = ST_RUN;
          sec_d   = 8'h00;
        end else if (inc_press_s) begin
          min_d = bcd_inc(min_q, MS_MAX);
        end else begin
          bcnt_d  = bcnt_step_s;
          blink_d = blink_step_s;
        end
      end
      default: begin
        state_d = ST_RUN;
        presc_d = '0;
      end
    endcase
  end

  // Digit mux: the field being edited reads as the blank glyph during blink phase 1.
  always_comb begin
    data1_d = hr_q[7:4];
    data2_d = hr_q[3:0];
    data3_d = min_q[7:4];
    data4_d = min_q[3:0];
    mode_d  = state_d;
    if (blink_q && (state_q == ST_SET_HR)) begin
      data1_d = BLANK_DIGIT;
      data2_d = BLANK_DIGIT;
    end else if (blink_q && (state_q == ST_SET_MIN)) begin
      data3_d = BLANK_DIGIT;
      data4_d = BLANK_DIGIT;
    end else begin
      data1_d = hr_q[7:4];
      data4_d = min_q[3:0];
    end
  end

  // Core state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      hr_q       <= 8'h00;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      presc_q    <= '0;
      bcnt_q     <= '0;
      blink_q    <= 1'b0;
      sec_tick_q <= 1'b0;
      mode_q     <= ST_RUN;
      data1_q    <= 4'h0;
      data2_q    <= 4'h0;
      data3_q    <= 4'h0;
      data4_q    <= 4'h0;
    end else begin
      state_q    <= state_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      presc_q    <= presc_d;
      bcnt_q     <= bcnt_d;
      blink_q    <= blink_d;
      sec_tick_q <= sec_tick_d;
      mode_q     <= mode_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      data3_q    <= data3_d;
      data4_q    <= data4_d;
    end
  end

  assign bus.data1    = data1_q;
  assign bus.data2    = data2_q;
  assign bus.data3    = data3_q;
  assign bus.data4    = data4_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.mode     = mode_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Scenario bench for clock_time_core with an integer hour/minute reference model.
module tb_clock_time_core;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam int BLINK  = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clock_time_core_if bus ();

  clock_time_core #(
    .CLK_HZ       (CLK_HZ),
    .DEBOUNCE_CYC (DEB),
    .BLINK_DIV    (BLINK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ticks    = 0;
  int          m_hr     = 0;
  int          m_min    = 0;
  logic [15:0] snap;

  always @(negedge clk) if (bus.sec_tick === 1'b1) ticks++;

  function automatic logic [15:0] exp_time(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {bus.data1, bus.data2, bus.data3, bus.data4};
  endfunction

  // Hold the selected buttons (bit0 mode, bit1 inc), capture digits 9 cycles in, then release.
  task automatic press(input int which, input int hold);
    bus.btn_mode = which[0];
    bus.btn_inc  = which[1];
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == 9) snap = digits();
    end
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({digits(), bus.sec_tick, bus.mode} !== 19'h0)
      $display("FAIL reset_outputs: got %h expected 0", {digits(), bus.sec_tick, bus.mode});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_run_minute();
    int nt = 0, first = -1, last = -1, bad = 0;
    for (int k = 1; k <= 605; k++) begin
      @(negedge clk);
      if (bus.sec_tick === 1'b1) begin
        nt++;
        if (first < 0) first = k;
        if (last >= 0 && (k - last) != CLK_HZ) bad++;
        last = k;
      end
    end
    m_hr = 0; m_min = 1;
    n_checks++;
    if (first !== CLK_HZ) $display("FAIL first_tick: got %0d expected %0d", first, CLK_HZ);
    else n_pass++;
    n_checks++;
    if (nt !== 60) $display("FAIL tick_count: got %0d expected 60", nt); else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL tick_spacing: got %0d bad gaps expected 0", bad); else n_pass++;
    n_checks++;
    if (digits() !== exp_time(m_hr, m_min))
      $display("FAIL minute_digits: got %h expected %h", digits(), exp_time(m_hr, m_min));
    else n_pass++;
  endtask

  task automatic test_buttons();
    int g;
    g = $urandom_range(1, 2);
    bus.btn_mode = 1'b1;
    repeat (g) @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.mode !== 2'b00) $display("FAIL glitch_rejected: got %b expected 00", bus.mode);
    else n_pass++;
    bus.btn_mode = 1'b1;
    repeat (6) @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus.mode !== 2'b01) $display("FAIL mode_to_set_hr: got %b expected 01", bus.mode);
    else n_pass++;
    press(2, 50);
    repeat (4) @(negedge clk);
    m_hr = 1;
    n_checks++;
    if (snap !== exp_time(m_hr, m_min))
      $display("FAIL inc_hold_once: got %h expected %h", snap, exp_time(m_hr, m_min));
    else n_pass++;
  endtask

  task automatic test_set_wrap();
    int t0, r;
    t0 = ticks;
    r  = $urandom_range(1, 4);
    while (m_hr != 23 + r) begin
      press(2, $urandom_range(10, 14));
      m_hr++;
      n_checks++;
      if (snap !== exp_time(m_hr % 24, m_min))
        $display("FAIL set_hr_inc: got %h expected %h", snap, exp_time(m_hr % 24, m_min));
      else n_pass++;
    end
    m_hr = m_hr % 24;
    press(1, $urandom_range(10, 14));
    n_checks++;
    if (bus.mode !== 2'b10 || snap !== exp_time(m_hr, m_min))
      $display("FAIL enter_set_min: got %b/%h expected 10/%h", bus.mode, snap, exp_time(m_hr, m_min));
    else n_pass++;
    for (int i = 0; i < 60; i++) begin
      press(2, $urandom_range(10, 14));
      m_min = (m_min + 1) % 60;
      n_checks++;
      if (snap !== exp_time(m_hr, m_min))
        $display("FAIL set_min_inc: got %h expected %h", snap, exp_time(m_hr, m_min));
      else n_pass++;
    end
    n_checks++;
    if (ticks !== t0) $display("FAIL no_tick_in_set: got %0d expected %0d", ticks, t0);
    else n_pass++;
  endtask

  task automatic test_blink();
    int found = 0;
    press(1, $urandom_range(10, 14));
    n_checks++;
    if (bus.mode !== 2'b00 || snap !== exp_time(m_hr, m_min))
      $display("FAIL back_to_run: got %b/%h expected 00/%h", bus.mode, snap, exp_time(m_hr, m_min));
    else n_pass++;
    press(1, $urandom_range(10, 14));
    bus.btn_mode = 1'b1;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.mode === 2'b10) found = 1;
    end
    bus.btn_mode = 1'b0;
    n_checks++;
    if (found !== 1) $display("FAIL reach_set_min: got mode %b expected 10", bus.mode);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (digits() !== exp_time(m_hr, m_min))
      $display("FAIL blink_entry_phase0: got %h expected %h", digits(), exp_time(m_hr, m_min));
    else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++;
    if (digits() !== {exp_time(m_hr, m_min) >> 8, 8'hFF})
      $display("FAIL blink_min_blank: got %h expected %h", digits(), {exp_time(m_hr, m_min) >> 8, 8'hFF});
    else n_pass++;
    repeat (6) @(negedge clk);
    m_min = (m_min + 1) % 60;
    bus.btn_inc = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 9 || i == 11) begin
        n_checks++;
        if (digits() !== exp_time(m_hr, m_min))
          $display("FAIL inc_unblanks: got %h expected %h at %0d", digits(), exp_time(m_hr, m_min), i);
        else n_pass++;
      end
    end
    bus.btn_inc = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_run();
    int k_tick = -1;
    press(1, $urandom_range(10, 14));
    n_checks++;
    if (bus.mode !== 2'b00 || snap !== exp_time(m_hr, m_min))
      $display("FAIL run_before_reset: got %b/%h expected 00/%h", bus.mode, snap, exp_time(m_hr, m_min));
    else n_pass++;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({digits(), bus.sec_tick, bus.mode} !== 19'h0)
      $display("FAIL async_reset: got %h expected 0", {digits(), bus.sec_tick, bus.mode});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30 && k_tick < 0; k++) begin
      @(negedge clk);
      if (bus.sec_tick === 1'b1) k_tick = k;
    end
    m_hr = 0; m_min = 0;
    n_checks++;
    if (k_tick !== CLK_HZ) $display("FAIL tick_after_reset: got %0d expected %0d", k_tick, CLK_HZ);
    else n_pass++;
    press(3, 12);
    n_checks++;
    if (bus.mode !== 2'b01 || snap !== exp_time(m_hr, m_min))
      $display("FAIL mode_wins_over_inc: got %b/%h expected 01/%h", bus.mode, snap, exp_time(m_hr, m_min));
    else n_pass++;
  endtask

  task automatic test_rollover();
    int found = 0, nt = 0;
    while (m_hr != 23) begin
      press(2, $urandom_range(10, 14));
      m_hr++;
    end
    press(1, $urandom_range(10, 14));
    while (m_min != 59) begin
      press(2, $urandom_range(10, 14));
      m_min++;
    end
    n_checks++;
    if (snap !== exp_time(23, 59)) $display("FAIL preset_2359: got %h expected %h", snap, exp_time(23, 59));
    else n_pass++;
    bus.btn_mode = 1'b1;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.mode === 2'b00) found = 1;
    end
    bus.btn_mode = 1'b0;
    n_checks++;
    if (found !== 1) $display("FAIL reach_run: got mode %b expected 00", bus.mode); else n_pass++;
    for (int k = 1; k <= 615; k++) begin
      @(negedge clk);
      if (bus.sec_tick === 1'b1) begin
        nt++;
        if (nt == 1) begin
          n_checks++;
          if (k !== CLK_HZ) $display("FAIL first_tick_after_set: got %0d expected %0d", k, CLK_HZ);
          else n_pass++;
        end
        if (nt == 60) begin
          n_checks++;
          if (k !== 60 * CLK_HZ || digits() !== exp_time(23, 59))
            $display("FAIL tick60_timing: got %0d/%h expected %0d/%h", k, digits(), 60 * CLK_HZ, exp_time(23, 59));
          else n_pass++;
        end
      end
      if (k == 60 * CLK_HZ + 1 || k == 615) begin
        n_checks++;
        if (digits() !== exp_time(0, 0))
          $display("FAIL midnight_rollover: got %h expected %h at %0d", digits(), exp_time(0, 0), k);
        else n_pass++;
      end
    end
    n_checks++;
    if (nt !== 61) $display("FAIL rollover_tick_count: got %0d expected 61", nt); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_run_minute();
    test_buttons();
    test_set_wrap();
    test_blink();
    test_reset_run();
    test_rollover();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
